// File: rtl/cam_pkg.sv
// Shared constants, state encoding and request-entry sizing for the
// CAM request scheduler.
package cam_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_SEARCH = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One queued request is {op, data, addr}.
    function automatic int req_entry_w(input int data_w, input int addr_w);
        return 1 + data_w + addr_w;
    endfunction

    localparam int ENTRY_W_DEF = req_entry_w(DATA_W_DEF, ADDR_W_DEF);

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO; push and pop in the same cycle are both honoured.
module req_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/cam_request_scheduler.sv
// Front-end for the CAM: buffers write/search requests, issues them one at
// a time in order, and returns registered search results under backpressure.
module cam_request_scheduler
    import cam_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_op,
    input  logic [DATA_W-1:0] i_req_data,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_cam_wen,
    output logic              o_cam_ren,
    output logic [DATA_W-1:0] o_cam_din,
    output logic [ADDR_W-1:0] o_cam_addr,
    input  logic [ADDR_W-1:0] i_cam_dout,
    input  logic              i_cam_hit,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_key,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic              o_rsp_hit
);

    localparam int ENTRY_W = req_entry_w(DATA_W, ADDR_W);

    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic               w_head_op;
    logic [DATA_W-1:0]  w_head_data;
    logic [ADDR_W-1:0]  w_head_addr;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    state_t             r_state;
    logic               r_op;
    logic [DATA_W-1:0]  r_key;
    logic               r_cam_wen;
    logic               r_cam_ren;
    logic [DATA_W-1:0]  r_cam_din;
    logic [ADDR_W-1:0]  r_cam_addr;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_key;
    logic [ADDR_W-1:0]  r_rsp_addr;
    logic               r_rsp_hit;

    state_t             w_state_nxt;
    logic               w_op_nxt;
    logic [DATA_W-1:0]  w_key_nxt;
    logic               w_cam_wen_nxt;
    logic               w_cam_ren_nxt;
    logic [DATA_W-1:0]  w_cam_din_nxt;
    logic [ADDR_W-1:0]  w_cam_addr_nxt;
    logic               w_rsp_valid_nxt;
    logic [DATA_W-1:0]  w_rsp_key_nxt;
    logic [ADDR_W-1:0]  w_rsp_addr_nxt;
    logic               w_rsp_hit_nxt;

    assign o_req_ready = !w_full;
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_push_data = {i_req_op, i_req_data, i_req_addr};

    assign w_head_op   = w_head[ENTRY_W-1];
    assign w_head_data = w_head[ADDR_W +: DATA_W];
    assign w_head_addr = w_head[ADDR_W-1:0];

    req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_head)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_key_nxt       = r_key;
        w_cam_wen_nxt   = 1'b0;
        w_cam_ren_nxt   = 1'b0;
        w_cam_din_nxt   = r_cam_din;
        w_cam_addr_nxt  = r_cam_addr;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_key_nxt   = r_rsp_key;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_hit_nxt   = r_rsp_hit;

        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_op_nxt      = w_head_op;
                    w_cam_din_nxt = w_head_data;
                    if (w_head_op == OP_WRITE) begin
                        w_cam_wen_nxt  = 1'b1;
                        w_cam_addr_nxt = w_head_addr;
                    end else begin
                        w_cam_ren_nxt = 1'b1;
                        w_key_nxt     = w_head_data;
                    end
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // The CAM samples the strobe at this edge.
                w_state_nxt = (r_op == OP_SEARCH) ? WAIT : IDLE;
            end
            WAIT: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_key_nxt   = r_key;
                w_rsp_addr_nxt  = i_cam_dout;
                w_rsp_hit_nxt   = i_cam_hit;
                w_state_nxt     = RESP;
            end
            RESP: begin
                if (r_rsp_valid && i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_op        <= OP_WRITE;
            r_key       <= '0;
            r_cam_wen   <= 1'b0;
            r_cam_ren   <= 1'b0;
            r_cam_din   <= '0;
            r_cam_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_key   <= '0;
            r_rsp_addr  <= '0;
            r_rsp_hit   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_key       <= w_key_nxt;
            r_cam_wen   <= w_cam_wen_nxt;
            r_cam_ren   <= w_cam_ren_nxt;
            r_cam_din   <= w_cam_din_nxt;
            r_cam_addr  <= w_cam_addr_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_key   <= w_rsp_key_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_hit   <= w_rsp_hit_nxt;
        end
    end

    assign o_cam_wen   = r_cam_wen;
    assign o_cam_ren   = r_cam_ren;
    assign o_cam_din   = r_cam_din;
    assign o_cam_addr  = r_cam_addr;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_key   = r_rsp_key;
    assign o_rsp_addr  = r_rsp_addr;
    assign o_rsp_hit   = r_rsp_hit;

endmodule

// File: tb/tb_cam_request_scheduler.sv
// Bench for cam_request_scheduler: behavioural CAM, in-order response
// model, per-cycle compare process and directed scenarios.
module tb_cam_request_scheduler;
    import cam_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NE = 16;

    typedef struct packed {
        logic [DW-1:0] key;
        logic [AW-1:0] addr;
        logic          hit;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [DW-1:0] req_data;
    logic [AW-1:0] req_addr;
    logic          cam_wen;
    logic          cam_ren;
    logic [DW-1:0] cam_din;
    logic [AW-1:0] cam_addr;
    logic [AW-1:0] cam_dout;
    logic          cam_hit;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_key;
    logic [AW-1:0] rsp_addr;
    logic          rsp_hit;

    always #5 clk = ~clk;

    cam_request_scheduler #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_data  (req_data),
        .i_req_addr  (req_addr),
        .o_cam_wen   (cam_wen),
        .o_cam_ren   (cam_ren),
        .o_cam_din   (cam_din),
        .o_cam_addr  (cam_addr),
        .i_cam_dout  (cam_dout),
        .i_cam_hit   (cam_hit),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_key   (rsp_key),
        .o_rsp_addr  (rsp_addr),
        .o_rsp_hit   (rsp_hit)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    // Physical CAM: registered highest-address match.
    logic [DW-1:0] cam_mem [NE];
    logic          cam_vld [NE];

    always @(posedge clk) begin
        if (cam_wen) begin
            cam_mem[cam_addr] <= cam_din;
            cam_vld[cam_addr] <= 1'b1;
        end
        if (cam_ren) begin : srch
            logic          h;
            logic [AW-1:0] a;
            h = 1'b0;
            a = '0;
            for (int i = 0; i < NE; i++) begin
                if (cam_vld[i] && cam_mem[i] == cam_din) begin
                    h = 1'b1;
                    a = AW'(i);
                end
            end
            cam_hit  <= h;
            cam_dout <= a;
        end
    end

    // Logical model: requests take effect in acceptance order.
    logic [DW-1:0] mdl_key [NE];
    logic          mdl_vld [NE];
    rsp_t          exp_q [$];
    rsp_t          log_q [$];

    task automatic accept(input logic op, input logic [DW-1:0] d,
                          input logic [AW-1:0] a);
        rsp_t e;
        if (op == OP_WRITE) begin
            mdl_key[a] = d;
            mdl_vld[a] = 1'b1;
        end else begin
            e.key  = d;
            e.addr = '0;
            e.hit  = 1'b0;
            for (int i = 0; i < NE; i++) begin
                if (mdl_vld[i] && mdl_key[i] == d) begin
                    e.hit  = 1'b1;
                    e.addr = AW'(i);
                end
            end
            exp_q.push_back(e);
        end
    endtask

    int   cyc = 0;
    int   wen_hi = 0;
    int   ren_hi = 0;
    int   wen_rise_q [$];
    int   ren_rise_q [$];
    int   rsp_rise_q [$];
    logic prev_wen = 1'b0;
    logic prev_ren = 1'b0;
    logic prev_rv = 1'b0;
    logic hold = 1'b0;
    rsp_t held;
    rsp_t mon_act;
    rsp_t mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon_act = '{key: rsp_key, addr: rsp_addr, hit: rsp_hit};
        if (cam_wen) wen_hi++;
        if (cam_ren) ren_hi++;
        if (cam_wen && !prev_wen) wen_rise_q.push_back(cyc);
        if (cam_ren && !prev_ren) ren_rise_q.push_back(cyc);
        if (rsp_valid && !prev_rv) rsp_rise_q.push_back(cyc);
        prev_wen = cam_wen;
        prev_ren = cam_ren;
        prev_rv  = rsp_valid;
        if (rst) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            check("wen_ren_excl", 32'(cam_wen & cam_ren), 0);
            if (hold) begin
                check("rsp_hold_valid", 32'(rsp_valid), 1);
                check("rsp_hold_data", 32'(mon_act), 32'(held));
            end
            if (req_valid && req_ready) accept(req_op, req_data, req_addr);
            if (rsp_valid && rsp_ready) begin
                log_q.push_back(mon_act);
                check("rsp_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("rsp_data", 32'(mon_act), 32'(mon_exp));
                end
            end
            hold = rsp_valid && !rsp_ready;
            held = mon_act;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [DW-1:0] d,
                        input logic [AW-1:0] a);
        bit ok = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_addr  = a;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_accepted", 32'(ok), 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check({nm, "_drain"}, 32'(ok), 1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input int idx,
                           input logic [DW-1:0] k, input logic [AW-1:0] a,
                           input logic h);
        rsp_t r;
        r = '{key: k, addr: a, hit: h};
        if (log_q.size() > idx) check(nm, 32'(log_q[idx]), 32'(r));
        else check({nm, "_present"}, log_q.size(), idx + 1);
    endtask

    task automatic chk_idle_outputs(input string p);
        check({p, "_cam_wen"}, 32'(cam_wen), 0);
        check({p, "_cam_ren"}, 32'(cam_ren), 0);
        check({p, "_cam_din"}, 32'(cam_din), 0);
        check({p, "_cam_addr"}, 32'(cam_addr), 0);
        check({p, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({p, "_rsp_key"}, 32'(rsp_key), 0);
        check({p, "_rsp_addr"}, 32'(rsp_addr), 0);
        check({p, "_rsp_hit"}, 32'(rsp_hit), 0);
        check({p, "_req_ready"}, 32'(req_ready), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] keys3 [6];
        logic [DW-1:0] wk [5];
        logic [AW-1:0] wa [5];
        int lb, sw, sr, sp, hw, hr, acc, j;
        bit ok;

        for (int i = 0; i < NE; i++) begin
            cam_vld[i] = 1'b0;
            mdl_vld[i] = 1'b0;
            cam_mem[i] = '0;
            mdl_key[i] = '0;
        end
        cam_dout  = '0;
        cam_hit   = 1'b0;
        keys3     = '{8'd50, 8'd2, 8'd20, 8'd7, 8'd99, 8'd13};
        wk        = '{8'd62, 8'd63, 8'd64, 8'd65, 8'd66};
        wa        = '{4'd7, 4'd8, 4'd9, 4'd5, 4'd6};
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = '0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_outputs("reset");

        // Back-to-back writes then searches.
        send(OP_WRITE, 8'd50, 4'd15);
        send(OP_WRITE, 8'd2, 4'd14);
        send(OP_WRITE, 8'd2, 4'd13);
        lb = log_q.size();
        send(OP_SEARCH, 8'd50, 4'd0);
        send(OP_SEARCH, 8'd2, 4'd0);
        send(OP_SEARCH, 8'd20, 4'd0);
        wait_drain("t1");
        chk_log("t1_rsp0", lb, 8'd50, 4'd15, 1'b1);
        chk_log("t1_rsp1", lb + 1, 8'd2, 4'd14, 1'b1);
        chk_log("t1_rsp2", lb + 2, 8'd20, 4'd0, 1'b0);

        // Write immediately followed by a search of the same key.
        lb = log_q.size();
        sw = wen_rise_q.size();
        sr = ren_rise_q.size();
        sp = rsp_rise_q.size();
        hw = wen_hi;
        hr = ren_hi;
        send(OP_WRITE, 8'd7, 4'd3);
        send(OP_SEARCH, 8'd7, 4'd0);
        wait_drain("t2");
        check("t2_wen_cycles", wen_hi - hw, 1);
        check("t2_ren_cycles", ren_hi - hr, 1);
        if (wen_rise_q.size() > sw && ren_rise_q.size() > sr)
            check("t2_ren_after_wen", ren_rise_q[sr] - wen_rise_q[sw], 2);
        else
            check("t2_pulses_seen", 0, 1);
        if (rsp_rise_q.size() > sp && ren_rise_q.size() > sr)
            check("t2_rsp_after_ren", rsp_rise_q[sp] - ren_rise_q[sr], 2);
        else
            check("t2_rsp_seen", 0, 1);
        chk_log("t2_rsp", lb, 8'd7, 4'd3, 1'b1);

        // Backpressure: six searches offered, consumer stalled.
        lb = log_q.size();
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            req_valid = (acc < 6);
            req_op    = OP_SEARCH;
            req_data  = keys3[(acc < 6) ? acc : 5];
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            tick();
        end
        @(negedge clk);
        check("t3_accepted", acc, 5);
        check("t3_req_ready_low", 32'(req_ready), 0);
        check("t3_rsp_valid", 32'(rsp_valid), 1);
        repeat (10) @(negedge clk);
        check("t3_rsp_key_held", 32'(rsp_key), 50);
        check("t3_rsp_valid_held", 32'(rsp_valid), 1);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("t3");
        check("t3_req_ready_back", 32'(req_ready), 1);
        chk_log("t3_rsp0", lb, 8'd50, 4'd15, 1'b1);
        chk_log("t3_rsp1", lb + 1, 8'd2, 4'd14, 1'b1);
        chk_log("t3_rsp2", lb + 2, 8'd20, 4'd0, 1'b0);
        chk_log("t3_rsp3", lb + 3, 8'd7, 4'd3, 1'b1);
        chk_log("t3_rsp4", lb + 4, 8'd99, 4'd0, 1'b0);

        // Push and pop together while two entries are queued.
        lb = log_q.size();
        rsp_ready = 1'b0;
        send(OP_SEARCH, 8'd50, 4'd0);
        send(OP_WRITE, 8'd60, 4'd5);
        send(OP_WRITE, 8'd61, 4'd6);
        @(negedge clk);
        check("t4_prefill", 32'(dut.u_fifo.r_count), 2);
        tick();
        rsp_ready = 1'b1;
        j = 0;
        for (int c = 0; c < 40 && j < 5; c++) begin
            req_valid = dut.w_pop;
            req_op    = OP_WRITE;
            req_data  = wk[j];
            req_addr  = wa[j];
            @(negedge clk);
            ok = req_valid && req_ready && dut.w_pop;
            tick();
            if (ok) begin
                check("t4_count_same", 32'(dut.u_fifo.r_count), 2);
                j++;
            end
        end
        req_valid = 1'b0;
        check("t4_pushpop_events", j, 5);
        send(OP_SEARCH, 8'd60, 4'd0);
        send(OP_SEARCH, 8'd65, 4'd0);
        send(OP_SEARCH, 8'd66, 4'd0);
        send(OP_SEARCH, 8'd62, 4'd0);
        wait_drain("t4");
        chk_log("t4_rsp0", lb, 8'd50, 4'd15, 1'b1);
        chk_log("t4_rsp1", lb + 1, 8'd60, 4'd0, 1'b0);
        chk_log("t4_rsp2", lb + 2, 8'd65, 4'd5, 1'b1);
        chk_log("t4_rsp3", lb + 3, 8'd66, 4'd6, 1'b1);
        chk_log("t4_rsp4", lb + 4, 8'd62, 4'd7, 1'b1);

        // Reset while a search waits for its CAM result.
        lb = log_q.size();
        send(OP_SEARCH, 8'd2, 4'd0);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cam_ren) begin
                ok = 1;
                break;
            end
        end
        check("t5_ren_seen", 32'(ok), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rsp_valid", 32'(rsp_valid), 0);
        check("t5_cam_ren", 32'(cam_ren), 0);
        check("t5_req_ready", 32'(req_ready), 1);
        repeat (10) tick();
        check("t5_no_rsp", log_q.size() - lb, 0);
        send(OP_SEARCH, 8'd50, 4'd0);
        send(OP_SEARCH, 8'd2, 4'd0);
        wait_drain("t5");
        chk_log("t5_rsp0", lb, 8'd50, 4'd15, 1'b1);
        chk_log("t5_rsp1", lb + 1, 8'd2, 4'd14, 1'b1);

        // Reset with requests queued.
        lb = log_q.size();
        rsp_ready = 1'b0;
        send(OP_SEARCH, 8'd50, 4'd0);
        send(OP_SEARCH, 8'd2, 4'd0);
        send(OP_SEARCH, 8'd20, 4'd0);
        send(OP_SEARCH, 8'd7, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hw = wen_hi;
        hr = ren_hi;
        chk_idle_outputs("t6_edge");
        rsp_ready = 1'b1;
        repeat (12) tick();
        check("t6_no_wen", wen_hi - hw, 0);
        check("t6_no_ren", ren_hi - hr, 0);
        check("t6_no_rsp", log_q.size() - lb, 0);
        chk_idle_outputs("t6_later");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_request_scheduler.md
Name: cam_request_scheduler

Overview:
- Upstream front-end for the 16-entry x 8-bit Content_Addressable_Memory.
- Accepts write and search requests over a valid/ready interface and buffers them in a small FIFO.
- Issues requests to the CAM strictly one at a time, in order.
- For each search, captures the CAM's registered dout/hit and returns it as a response under valid/ready backpressure. Writes produce no response.

Parameters:
- DATA_W, 8, CAM key width
- ADDR_W, 4, CAM address width (2**ADDR_W entries)
- DEPTH, 4, request FIFO depth (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept a request (= !full)
- req_op  in  1  0 = write, 1 = search
- req_data  in  DATA_W  key to write or search
- req_addr  in  ADDR_W  write address (ignored for search)
- cam_wen  out  1  to CAM wen
- cam_ren  out  1  to CAM ren
- cam_din  out  DATA_W  to CAM din
- cam_addr  out  ADDR_W  to CAM addr
- cam_dout  in  ADDR_W  from CAM: highest matching address, registered
- cam_hit  in  1  from CAM: match found, registered
- rsp_valid  out  1  search result available
- rsp_ready  in  1  consumer accepts result
- rsp_key  out  DATA_W  key that was searched
- rsp_addr  out  ADDR_W  matching address (0 on miss)
- rsp_hit  out  1  search hit

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state updates occur on the rising edge of clk.
- CAM contract:
  - CAM samples wen/ren/din/addr at a rising edge.
  - Search results (dout, hit) are valid during the following cycle.
  - A write is visible to any search issued at a later edge.
  - cam_wen and cam_ren are never both 1.
- Reset values: cam_wen = 0, cam_ren = 0, cam_din = 0, cam_addr = 0, rsp_valid = 0, rsp_key = 0, rsp_addr = 0, rsp_hit = 0. FIFO empty, so req_ready = 1. state = IDLE.
- FIFO:
  - Push on req_valid && req_ready.
  - Pop only from IDLE when the FIFO is non-empty.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - req_ready derives from the registered count only, never from the pop in the current cycle.
  - Pointers wrap modulo DEPTH.
- FSM, with all outputs registered:
  - IDLE:
    - FIFO empty: stay in IDLE with cam_wen = cam_ren = 0.
    - Otherwise pop the head.
    - Write: cam_wen <= 1, cam_din <= data, cam_addr <= addr.
    - Search: cam_ren <= 1, cam_din <= data, latch the key.
    - Go to ISSUE.
  - ISSUE: the CAM samples at this edge. cam_wen <= 0 and cam_ren <= 0. Write: go to IDLE. Search: go to WAIT.
  - WAIT: rsp_addr <= cam_dout, rsp_hit <= cam_hit, rsp_key <= latched key, rsp_valid <= 1. Go to RESP.
  - RESP: hold all rsp_* stable. On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
- cam_din and cam_addr hold their last issued values while idle.
- Latency:
  - Write occupies 2 cycles, pop to IDLE.
  - Search: rsp_valid rises 3 edges after the pop edge.
  - No new request is popped while a response is pending.
- Ordering: strictly in order, so a search queued after a write always observes that write.
- Miss: rsp_hit = 0 and rsp_addr = 0, propagated directly from the CAM.
- Reset mid-operation:
  - Any in-flight request is dropped and no response is emitted.
  - The FIFO is flushed.
  - cam_wen and cam_ren are 0 from the reset edge.
  - CAM contents are not affected.

Decomposition:
- Package cam_pkg holds:
  - DATA_W and ADDR_W defaults
  - OP_WRITE = 0, OP_SEARCH = 1
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP (2 bits)
  - request entry width = 1 + DATA_W + ADDR_W
- One sub-module, req_fifo: synchronous FIFO of DEPTH entries, with push, pop, full, empty and head-data outputs, reset by rst.
- The scheduler FSM and response registers live in the top module.

Test Plan:
- Write 50@15, 2@14, 2@13 back-to-back, then search 50, 2, 20 with rsp_ready = 1. Required responses, in order: (key 50, addr 15, hit 1), (key 2, addr 14, hit 1), (key 20, addr 0, hit 0).
- Write 7@3 and immediately search 7 on the next cycle. Required: cam_wen pulses for exactly 1 cycle, cam_ren pulses 2 cycles later, response is (addr 3, hit 1).
- Hold rsp_ready = 0 and drive 6 search requests with req_valid held high. Required: exactly 5 accepted, after which req_ready = 0. The first response stays stable for 10 cycles. Releasing rsp_ready drains the responses in order, and req_ready returns to 1.
- Simultaneous push and pop while the FIFO holds 2 entries. Required: count stays at 2 and the FIFO wrap-around preserves order across more than DEPTH total requests.
- Assert rst for 1 cycle while in WAIT during a search. Required: after that edge rsp_valid = 0, cam_ren = 0, req_ready = 1. No response for the dropped search appears afterwards, and earlier CAM writes still hit.
- Assert rst with requests queued. Required: the queue is flushed, no cam_wen or cam_ren pulses occur afterwards, and all outputs are at their reset values.
